// File: rtl/debounce_bank_if.sv
// Pin-side bundle for debounce_bank: raw pin levels in, debounced level and
// per-channel event pulses out.
interface debounce_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] held;
  logic [CHANNELS-1:0] rpt;

  // master drives the pins and consumes the pulses; slave is the debouncer
  modport master (
    output raw_in,
    input  level, rise, fall, held, rpt
  );

  modport slave (
    input  raw_in,
    output level, rise, fall, held, rpt
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: 2-flop synchroniser, stability-window
// debounce, press/release edge pulses and long-press / auto-repeat pulses.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int HOLD_CYCLES   = 10000000,
  parameter int REPEAT_CYCLES = 2500000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  debounce_bank_if.slave bank
);

  localparam int DW   = $clog2(STABLE_CYCLES);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX);

  localparam logic [DW-1:0] D_LAST = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);
  localparam bit            RPT_EN = (REPEAT_CYCLES > 0);

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  // Synchroniser idles at the "not pressed" pin level so reset never looks like a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {CHANNELS{ACTIVE_LOW}};
      r_sync2 <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      r_sync1 <= bank.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic          w_s;
      logic          w_settle;
      logic          w_release;
      logic          r_level;
      logic          r_rise;
      logic          r_fall;
      logic          r_held;
      logic          r_rpt;
      logic          r_phase;
      logic [DW-1:0] r_dcnt;
      logic [HW-1:0] r_hcnt;

      assign w_s       = r_sync2[gi] ^ ACTIVE_LOW;
      assign w_settle  = (w_s != r_level) && (r_dcnt == D_LAST);
      // level is about to drop on this edge: any pending held/rpt is discarded
      assign w_release = w_settle && r_level;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_level <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
          r_held  <= 1'b0;
          r_rpt   <= 1'b0;
          r_phase <= 1'b0;
          r_dcnt  <= '0;
          r_hcnt  <= '0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          r_held <= 1'b0;
          r_rpt  <= 1'b0;

          if (w_s == r_level) begin
            r_dcnt <= '0;
          end else if (w_settle) begin
            r_level <= w_s;
            r_dcnt  <= '0;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end

          if (!r_level || w_release) begin
            r_hcnt  <= '0;
            r_phase <= 1'b0;
          end else if (!r_phase) begin
            if (r_hcnt == H_LAST) begin
              r_held  <= 1'b1;
              r_hcnt  <= '0;
              r_phase <= 1'b1;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end else if (RPT_EN) begin
            if (r_hcnt == R_LAST) begin
              r_rpt  <= 1'b1;
              r_hcnt <= '0;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end
      end

      assign bank.level[gi] = r_level;
      assign bank.rise[gi]  = r_rise;
      assign bank.fall[gi]  = r_fall;
      assign bank.held[gi]  = r_held;
      assign bank.rpt[gi]   = r_rpt;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: one instance with auto-repeat, one with
// repeat disabled, driven by the same pins and checked every cycle.
module tb_debounce_bank;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  debounce_bank_if #(.CHANNELS(4)) ifa ();
  debounce_bank_if #(.CHANNELS(4)) ifb ();

  debounce_bank #(
    .CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bank(ifa.slave)
  );

  debounce_bank #(
    .CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bank(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       has_raw;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] held;
    logic [3:0] rpt;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [3:0] v);
    ifa.raw_in = v;
    ifb.raw_in = v;
  endtask

  task automatic chk(input string nm, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  // rpt_b is the expectation for the repeat-disabled instance
  task automatic chk_all(input int cyc, input logic [3:0] lvl, input logic [3:0] rise,
                         input logic [3:0] fall, input logic [3:0] held,
                         input logic [3:0] rpt_a, input logic [3:0] rpt_b);
    chk("a.level", cyc, ifa.level, lvl);
    chk("a.rise",  cyc, ifa.rise,  rise);
    chk("a.fall",  cyc, ifa.fall,  fall);
    chk("a.held",  cyc, ifa.held,  held);
    chk("a.rpt",   cyc, ifa.rpt,   rpt_a);
    chk("b.level", cyc, ifb.level, lvl);
    chk("b.rise",  cyc, ifb.rise,  rise);
    chk("b.fall",  cyc, ifb.fall,  fall);
    chk("b.held",  cyc, ifb.held,  held);
    chk("b.rpt",   cyc, ifb.rpt,   rpt_b);
  endtask

  initial begin
    logic [3:0] exp_lvl;
    int         hit;

    checks   = 0;
    failures = 0;

    // raw is driven just after the listed cycle; expected outputs are for that cycle.
    // ch0: press 0..20, repeats at 19/22/25, fall at 26.
    // ch1: 3-low / 1-high / 3-low glitch that must never settle.
    // ch2+ch3: pressed together at 40, release at 65 lands fall on a would-be rpt edge (71).
    tbl[0]  = '{0,  1'b1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{3,  1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4,  1'b1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{6,  1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{7,  1'b1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{16, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[6]  = '{19, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[7]  = '{20, 1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{22, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[9]  = '{25, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[10] = '{26, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = '{40, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{46, 1'b0, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{56, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 4'b0000};
    tbl[14] = '{59, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[15] = '{62, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[16] = '{65, 1'b1, 4'b1111, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[17] = '{68, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[18] = '{71, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000};

    reset_n = 1'b0;
    set_raw(4'b1111);
    step();
    step();
    chk_all(-1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;

    for (int c = 0; c < 50; c++) begin
      step();
      chk_all(c, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    $display("idle: 50 cycles checked with all pins released");

    exp_lvl = 4'b0000;
    step();
    for (int c = 0; c <= 80; c++) begin
      hit = -1;
      for (int k = 0; k < NVEC; k++) begin
        if (tbl[k].cyc == c) hit = k;
      end
      if (hit >= 0) begin
        exp_lvl = tbl[hit].lvl;
        chk_all(c, tbl[hit].lvl, tbl[hit].rise, tbl[hit].fall, tbl[hit].held,
                tbl[hit].rpt, 4'b0000);
        $display("vec cyc=%0d raw=%b level=%b rise=%b fall=%b held=%b rpt_a=%b rpt_b=%b",
                 c, ifa.raw_in, ifa.level, ifa.rise, ifa.fall, ifa.held, ifa.rpt, ifb.rpt);
        if (tbl[hit].has_raw) set_raw(tbl[hit].raw);
      end else begin
        chk_all(c, exp_lvl, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      if (c < 80) step();
    end

    // Reset in the middle of a hold, with ch0 still pressed throughout
    step();
    set_raw(4'b1110);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk_all(c, (c >= 6) ? 4'b0001 : 4'b0000, (c == 6) ? 4'b0001 : 4'b0000,
              4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    reset_n = 1'b0;
    #1;
    chk_all(12, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    $display("reset: asserted mid-hold level_a=%b level_b=%b", ifa.level, ifb.level);
    step();
    chk_all(13, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step();
    chk_all(14, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    for (int c = 15; c <= 21; c++) begin
      step();
      chk_all(c, (c >= 20) ? 4'b0001 : 4'b0000, (c == 20) ? 4'b0001 : 4'b0000,
              4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    $display("reset: released at 14, rise_a seen at 20 expected, level_a=%b", ifa.level);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
